// File: rtl/load_store_buffer_pkg.sv
// Shared configuration for the load/store buffer: queue and ROB tag sizes,
// RISC-V funct3 encodings for loads/stores and the FSM state encodings.
package load_store_buffer_pkg;

    localparam int LSB_SIZE_BIT = 3;
    localparam int ROB_SIZE_BIT = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Access size is the low two bits of funct3 for both loads and stores.
    function automatic logic [1:0] mem_len_of(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// lsb_load_extend: turns raw LSB-aligned memory read data into the
// architectural load result (sign-extend LB/LH, zero-extend LBU/LHU, LW as is).
module lsb_load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    // Select extension by load width and signedness.
    always_comb begin
        value = raw;
        case (funct3)
            F3_LB:   value = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   value = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  value = {24'b0, raw[7:0]};
            F3_LHU:  value = {16'b0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order circular queue of loads/stores. Operands are
// captured from the ALU and load-result broadcasts; only the head entry talks
// to memory through a one-outstanding-request FSM (IDLE/BUSY/DRAIN).
// Optional build macro: LSB_IO_ORDER_EN -- loads whose address has
// addr[17:16] == 2'b11 wait until they reach the ROB head, like stores.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_SIZE_BIT = load_store_buffer_pkg::LSB_SIZE_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    inst_valid,
    input  logic [3:0]              inst_op,
    input  logic [ROB_SIZE_BIT-1:0] inst_rob_idx,
    input  logic [31:0]             inst_imm,
    input  logic [ROB_SIZE_BIT:0]   inst_q1,
    input  logic [31:0]             inst_v1,
    input  logic [ROB_SIZE_BIT:0]   inst_q2,
    input  logic [31:0]             inst_v2,
    output logic                    full,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_BIT-1:0] alu_rob_idx,
    input  logic [31:0]             alu_value,
    input  logic [ROB_SIZE_BIT-1:0] rob_idx_head,
    input  logic                    clear,
    output logic                    lsb_st_ok,
    output logic                    lsb_valid,
    output logic [ROB_SIZE_BIT-1:0] lsb_rob_idx,
    output logic [31:0]             lsb_value,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [31:0]             mem_addr,
    output logic [1:0]              mem_len,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_done,
    input  logic [31:0]             mem_rdata
);

    localparam int DEPTH = 1 << LSB_SIZE_BIT;
    localparam int CNT_W = LSB_SIZE_BIT + 1;

    // Entry payload; occupancy is tracked by head/count, so no per-entry valid.
    logic [3:0]              op_q  [DEPTH];
    logic [ROB_SIZE_BIT-1:0] rob_q [DEPTH];
    logic [31:0]             imm_q [DEPTH];
    logic [ROB_SIZE_BIT:0]   q1_q  [DEPTH];
    logic [31:0]             v1_q  [DEPTH];
    logic [ROB_SIZE_BIT:0]   q2_q  [DEPTH];
    logic [31:0]             v2_q  [DEPTH];

    logic [1:0]              state;
    logic [LSB_SIZE_BIT-1:0] head;
    logic [LSB_SIZE_BIT-1:0] tail;
    logic [CNT_W-1:0]        count;

    logic [ROB_SIZE_BIT:0]   iss_q1, iss_q2;
    logic [31:0]             iss_v1, iss_v2;

    logic [3:0]              h_op;
    logic                    h_is_store;
    logic [31:0]             h_addr;
    logic                    h_ops_rdy;
    logic                    h_io_wait;
    logic                    h_go;
    logic                    fire, pop, push;
    logic [31:0]             ext_value;

    // A pending tag (MSB set) resolves when a valid broadcast carries its tag.
    function automatic logic tag_hit(input logic [ROB_SIZE_BIT:0]   q,
                                     input logic                    bvalid,
                                     input logic [ROB_SIZE_BIT-1:0] btag);
        return q[ROB_SIZE_BIT] && bvalid && (q[ROB_SIZE_BIT-1:0] == btag);
    endfunction

    // Forward same-cycle broadcasts into the operands of the entry being issued.
    always_comb begin
        iss_q1 = inst_q1;
        iss_v1 = inst_v1;
        iss_q2 = inst_q2;
        iss_v2 = inst_v2;
        if (tag_hit(inst_q1, alu_valid, alu_rob_idx)) begin
            iss_q1 = '0;
            iss_v1 = alu_value;
        end else if (tag_hit(inst_q1, lsb_valid, lsb_rob_idx)) begin
            iss_q1 = '0;
            iss_v1 = lsb_value;
        end
        if (tag_hit(inst_q2, alu_valid, alu_rob_idx)) begin
            iss_q2 = '0;
            iss_v2 = alu_value;
        end else if (tag_hit(inst_q2, lsb_valid, lsb_rob_idx)) begin
            iss_q2 = '0;
            iss_v2 = lsb_value;
        end
    end

    assign h_op       = op_q[head];
    assign h_is_store = h_op[3];
    assign h_addr     = v1_q[head] + imm_q[head];
    assign h_ops_rdy  = !q1_q[head][ROB_SIZE_BIT] &&
                        (!h_is_store || !q2_q[head][ROB_SIZE_BIT]);
`ifdef LSB_IO_ORDER_EN
    assign h_io_wait  = !h_is_store && (h_addr[17:16] == 2'b11);
`else
    assign h_io_wait  = 1'b0;
`endif
    // Stores (and IO loads when enabled) are non-speculative: they wait for the ROB head.
    assign h_go = (count != '0) && h_ops_rdy &&
                  (!(h_is_store || h_io_wait) || (rob_q[head] == rob_idx_head));

    assign fire = (state == ST_IDLE) && h_go && !clear;
    assign pop  = (state == ST_BUSY) && mem_done && !clear;
    assign push = inst_valid && !clear && ((count != CNT_W'(DEPTH)) || pop);
    assign full = (count >= CNT_W'(DEPTH - 1));

    lsb_load_extend u_extend (
        .funct3 (h_op[2:0]),
        .raw    (mem_rdata),
        .value  (ext_value)
    );

    // Entry payload: broadcast capture for waiting entries, then write of the issued entry.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tag_hit(q1_q[i], alu_valid, alu_rob_idx)) begin
                    q1_q[i] <= '0;
                    v1_q[i] <= alu_value;
                end else if (tag_hit(q1_q[i], lsb_valid, lsb_rob_idx)) begin
                    q1_q[i] <= '0;
                    v1_q[i] <= lsb_value;
                end
                if (tag_hit(q2_q[i], alu_valid, alu_rob_idx)) begin
                    q2_q[i] <= '0;
                    v2_q[i] <= alu_value;
                end else if (tag_hit(q2_q[i], lsb_valid, lsb_rob_idx)) begin
                    q2_q[i] <= '0;
                    v2_q[i] <= lsb_value;
                end
            end
            if (push) begin
                op_q[tail]  <= inst_op;
                rob_q[tail] <= inst_rob_idx;
                imm_q[tail] <= inst_imm;
                q1_q[tail]  <= iss_q1;
                v1_q[tail]  <= iss_v1;
                q2_q[tail]  <= iss_q2;
                v2_q[tail]  <= iss_v2;
            end
        end
    end

    // Queue pointers, memory FSM and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_len     <= '0;
            mem_wdata   <= '0;
            lsb_valid   <= 1'b0;
            lsb_st_ok   <= 1'b0;
            lsb_rob_idx <= '0;
            lsb_value   <= '0;
        end else if (rdy_in) begin
            lsb_valid <= 1'b0;
            lsb_st_ok <= 1'b0;
            if (push) tail <= tail + LSB_SIZE_BIT'(1);
            if (pop)  head <= head + LSB_SIZE_BIT'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state     <= ST_BUSY;
                        mem_req   <= 1'b1;
                        mem_wr    <= h_is_store;
                        mem_addr  <= h_addr;
                        mem_len   <= mem_len_of(h_op[2:0]);
                        mem_wdata <= v2_q[head];
                    end
                end
                ST_BUSY: begin
                    if (mem_done) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        if (!clear) begin
                            if (h_is_store) begin
                                lsb_st_ok <= 1'b1;
                            end else begin
                                lsb_valid   <= 1'b1;
                                lsb_rob_idx <= rob_q[head];
                                lsb_value   <= ext_value;
                            end
                        end
                    end else if (clear) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Outstanding access must complete; its result is dropped.
                    if (mem_done) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Scoreboard bench for load_store_buffer: expected memory requests and
// expected results are queued at issue time; a memory responder and a result
// monitor pop and compare independently of the stimulus.
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } mem_exp_t;

    typedef struct {
        logic                    is_store;
        logic [ROB_SIZE_BIT-1:0] rob;
        logic [31:0]             value;
    } res_exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] v1;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] value;
    } load_vec_t;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic                    rdy_in = 1'b1;
    logic                    inst_valid = 1'b0;
    logic [3:0]              inst_op = '0;
    logic [ROB_SIZE_BIT-1:0] inst_rob_idx = '0;
    logic [31:0]             inst_imm = '0;
    logic [ROB_SIZE_BIT:0]   inst_q1 = '0;
    logic [31:0]             inst_v1 = '0;
    logic [ROB_SIZE_BIT:0]   inst_q2 = '0;
    logic [31:0]             inst_v2 = '0;
    logic                    full;
    logic                    alu_valid = 1'b0;
    logic [ROB_SIZE_BIT-1:0] alu_rob_idx = '0;
    logic [31:0]             alu_value = '0;
    logic [ROB_SIZE_BIT-1:0] rob_idx_head = '0;
    logic                    clear = 1'b0;
    logic                    lsb_st_ok;
    logic                    lsb_valid;
    logic [ROB_SIZE_BIT-1:0] lsb_rob_idx;
    logic [31:0]             lsb_value;
    logic                    mem_req;
    logic                    mem_wr;
    logic [31:0]             mem_addr;
    logic [1:0]              mem_len;
    logic [31:0]             mem_wdata;
    logic                    mem_done = 1'b0;
    logic [31:0]             mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_exp_t exp_mem[$];
    res_exp_t exp_res[$];

    load_store_buffer dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .inst_valid   (inst_valid),
        .inst_op      (inst_op),
        .inst_rob_idx (inst_rob_idx),
        .inst_imm     (inst_imm),
        .inst_q1      (inst_q1),
        .inst_v1      (inst_v1),
        .inst_q2      (inst_q2),
        .inst_v2      (inst_v2),
        .full         (full),
        .alu_valid    (alu_valid),
        .alu_rob_idx  (alu_rob_idx),
        .alu_value    (alu_value),
        .rob_idx_head (rob_idx_head),
        .clear        (clear),
        .lsb_st_ok    (lsb_st_ok),
        .lsb_valid    (lsb_valid),
        .lsb_rob_idx  (lsb_rob_idx),
        .lsb_value    (lsb_value),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                            input logic cw, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay);
        mem_exp_t e;
        e.wr = wr; e.addr = addr; e.len = len; e.chk_wdata = cw;
        e.wdata = wdata; e.rdata = rdata; e.delay = delay;
        exp_mem.push_back(e);
    endtask

    task automatic push_res(input logic st, input logic [ROB_SIZE_BIT-1:0] rob,
                            input logic [31:0] value);
        res_exp_t r;
        r.is_store = st; r.rob = rob; r.value = value;
        exp_res.push_back(r);
    endtask

    // Issue one entry; called just after a rising edge, returns just after the next.
    task automatic issue(input logic [3:0] op, input logic [ROB_SIZE_BIT-1:0] rob,
                         input logic [31:0] imm, input logic [ROB_SIZE_BIT:0] q1,
                         input logic [31:0] v1, input logic [ROB_SIZE_BIT:0] q2,
                         input logic [31:0] v2);
        inst_op = op; inst_rob_idx = rob; inst_imm = imm;
        inst_q1 = q1; inst_v1 = v1; inst_q2 = q2; inst_v2 = v2;
        inst_valid = 1'b1;
        @(posedge clk_in); #1;
        inst_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (exp_mem.size() == 0 && exp_res.size() == 0 && !mem_req && !mem_done) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout mem_left=%0d res_left=%0d required=0/0",
                     name, exp_mem.size(), exp_res.size());
        end
        @(posedge clk_in); #1;
    endtask

    // Memory responder: checks each request as it appears, then pulses mem_done.
    initial begin
        mem_exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in && mem_req) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual addr=0x%08h wr=%0d required=no request",
                             mem_addr, mem_wr);
                    e.delay = 1;
                    e.rdata = '0;
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_wr", {31'b0, mem_wr}, {31'b0, e.wr});
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_len", {30'b0, mem_len}, {30'b0, e.len});
                    if (e.chk_wdata) chk("mem_wdata", mem_wdata, e.wdata);
                end
                repeat (e.delay) @(posedge clk_in);
                #1;
                mem_done  = 1'b1;
                mem_rdata = e.rdata;
                @(posedge clk_in); #1;
                mem_done  = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
        end
    end

    // Result monitor: every lsb_valid / lsb_st_ok cycle consumes one expectation.
    initial begin
        res_exp_t r;
        forever begin
            @(negedge clk_in);
            if (rst_in && (lsb_valid || lsb_st_ok)) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected actual valid=%0d st_ok=%0d tag=%0d value=0x%08h required=none",
                             lsb_valid, lsb_st_ok, lsb_rob_idx, lsb_value);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_st_ok", {31'b0, lsb_st_ok}, {31'b0, r.is_store});
                    chk("res_valid", {31'b0, lsb_valid}, {31'b0, !r.is_store});
                    if (!r.is_store) begin
                        chk("res_tag", {29'b0, lsb_rob_idx}, {29'b0, r.rob});
                        chk("res_value", lsb_value, r.value);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=time limit required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load_vec_t lv[6];
        bit found;

        lv[0] = '{F3_LB,  32'h0000_0100, 32'h4,  32'h0000_0080, 32'h0000_0104, 32'hFFFF_FF80};
        lv[1] = '{F3_LBU, 32'h0000_0100, 32'h5,  32'h0000_0080, 32'h0000_0105, 32'h0000_0080};
        lv[2] = '{F3_LH,  32'h0000_0200, 32'h10, 32'h0000_8001, 32'h0000_0210, 32'hFFFF_8001};
        lv[3] = '{F3_LHU, 32'h0000_0200, 32'h12, 32'h0000_8001, 32'h0000_0212, 32'h0000_8001};
        lv[4] = '{F3_LW,  32'hFFFF_FFFC, 32'h8,  32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF};
        lv[5] = '{F3_LB,  32'h0000_0000, 32'h3000, 32'h1234_567F, 32'h0000_3000, 32'h0000_007F};

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_full", {31'b0, full}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_lsb_valid", {31'b0, lsb_valid}, 32'h0);
        chk("rst_lsb_value", lsb_value, 32'h0);
        chk("rst_st_ok", {31'b0, lsb_st_ok}, 32'h0);
        chk("rst_count", {28'b0, dut.count}, 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        cycles(2);

        // Loads of every width/signedness, issued back to back
        for (int i = 0; i < 6; i++) begin
            push_mem(1'b0, lv[i].addr, mem_len_of(lv[i].f3), 1'b0, 32'h0, lv[i].rdata, 1 + (i % 3));
            push_res(1'b0, ROB_SIZE_BIT'(i), lv[i].value);
        end
        for (int i = 0; i < 6; i++)
            issue({1'b0, lv[i].f3}, ROB_SIZE_BIT'(i), lv[i].imm, 4'b0000, lv[i].v1, 4'b0000, 32'h0);
        wait_idle("loads", 200);

        // Store waits for ROB head
        rob_idx_head = 3'd3;
        issue({1'b1, F3_SW}, 3'd5, 32'h8, 4'b0000, 32'h0000_1000, 4'b0000, 32'hCAFE_F00D);
        cycles(4);
        chk("st_wait_no_req", {31'b0, mem_req}, 32'h0);
        push_mem(1'b1, 32'h0000_1008, 2'd2, 1'b1, 32'hCAFE_F00D, 32'h0, 2);
        push_res(1'b1, 3'd5, 32'h0);
        rob_idx_head = 3'd5;
        wait_idle("store", 50);

        // Same-cycle ALU forwarding on issue
        push_mem(1'b0, 32'h0000_0210, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 1);
        push_res(1'b0, 3'd6, 32'h1234_5678);
        alu_valid = 1'b1; alu_rob_idx = 3'd2; alu_value = 32'h0000_0200;
        issue({1'b0, F3_LW}, 3'd6, 32'h10, 4'b1010, 32'hFFFF_0000, 4'b0000, 32'h0);
        alu_valid = 1'b0;
        wait_idle("fwd_issue", 50);

        // Pending rs1 captured later from ALU broadcast
        issue({1'b0, F3_LW}, 3'd2, 32'h8, 4'b1100, 32'h0, 4'b0000, 32'h0);
        cycles(3);
        chk("pending_no_req", {31'b0, mem_req}, 32'h0);
        push_mem(1'b0, 32'h0000_0308, 2'd2, 1'b0, 32'h0, 32'h0000_00AA, 1);
        push_res(1'b0, 3'd2, 32'h0000_00AA);
        alu_valid = 1'b1; alu_rob_idx = 3'd4; alu_value = 32'h0000_0300;
        cycles(1);
        alu_valid = 1'b0;
        wait_idle("fwd_capture", 50);

        // Fill to full, then pop and issue in the same cycle
        rob_idx_head = 3'd7;
        for (int k = 0; k < 7; k++) begin
            issue({1'b1, (k == 0) ? F3_SH : F3_SW}, ROB_SIZE_BIT'(k), (k == 0) ? 32'h2 : 32'h0,
                  4'b0000, 32'h0000_1000 + 32'(k * 4), 4'b0000, 32'(k));
            if (k == 5) chk("full_at_6", {31'b0, full}, 32'h0);
        end
        chk("full_at_7", {31'b0, full}, 32'h1);
        chk("count_7", {28'b0, dut.count}, 32'h7);
        push_mem(1'b1, 32'h0000_1002, 2'd1, 1'b1, 32'h0, 32'h0, 3);
        push_res(1'b1, 3'd0, 32'h0);
        rob_idx_head = 3'd0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            if (mem_done) begin found = 1; break; end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL pop_wait timeout actual=no mem_done required=mem_done");
        end
        inst_op = {1'b1, F3_SW}; inst_rob_idx = 3'd7; inst_imm = 32'h0;
        inst_q1 = '0; inst_v1 = 32'h2000; inst_q2 = '0; inst_v2 = 32'h77;
        inst_valid = 1'b1;
        @(posedge clk_in); #1;
        inst_valid = 1'b0;
        chk("count_pop_issue", {28'b0, dut.count}, 32'h7);
        chk("full_pop_issue", {31'b0, full}, 32'h1);
        cycles(2);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("count_after_clear", {28'b0, dut.count}, 32'h0);
        chk("full_after_clear", {31'b0, full}, 32'h0);
        wait_idle("full_test", 50);

        // Clear during a BUSY load: request held, result dropped, issue ignored
        push_mem(1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 6);
        issue({1'b0, F3_LW}, 3'd1, 32'h0, 4'b0000, 32'h0000_0040, 4'b0000, 32'h0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (mem_req) begin found = 1; break; end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL drain_req timeout actual=no mem_req required=mem_req");
        end
        @(posedge clk_in); #1;
        clear = 1'b1;
        inst_op = {1'b0, F3_LW}; inst_rob_idx = 3'd3; inst_imm = 32'h0;
        inst_q1 = '0; inst_v1 = 32'h0000_0ABC; inst_q2 = '0; inst_v2 = 32'h0;
        inst_valid = 1'b1;
        @(posedge clk_in); #1;
        clear = 1'b0;
        inst_valid = 1'b0;
        chk("drain_req_held", {31'b0, mem_req}, 32'h1);
        chk("drain_count", {28'b0, dut.count}, 32'h0);
        wait_idle("drain", 50);
        cycles(3);
        chk("drain_count_end", {28'b0, dut.count}, 32'h0);

        // Back in IDLE: a fresh load completes normally
        push_mem(1'b0, 32'h0000_0520, 2'd0, 1'b0, 32'h0, 32'h0000_007F, 1);
        push_res(1'b0, 3'd4, 32'h0000_007F);
        issue({1'b0, F3_LB}, 3'd4, 32'h20, 4'b0000, 32'h0000_0500, 4'b0000, 32'h0);
        wait_idle("after_drain", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_buffer.md
LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 SHALL have parameter LSB_SIZE_BIT, default 3, giving log2 of the entry count (8 entries).
REQ-002 clk_in  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_in  in  1  reset, asynchronous and active-low.
REQ-004 rdy_in  in  1  pause; when low, no state changes and no new requests.
REQ-005 inst_valid  in  1  issue an entry this cycle.
REQ-006 inst_op  in  4  {is_store, funct3}.
REQ-007 inst_rob_idx  in  ROB_SIZE_BIT  ROB tag of the instruction.
REQ-008 inst_imm  in  32  address offset.
REQ-009 inst_q1  in  ROB_SIZE_BIT+1  rs1 tag; MSB=1 means pending.
REQ-010 inst_v1  in  32  rs1 value when not pending.
REQ-011 inst_q2  in  ROB_SIZE_BIT+1  rs2 tag (store data); MSB=1 means pending.
REQ-012 inst_v2  in  32  rs2 value when not pending.
REQ-013 full  out  1  decoder must not issue.
REQ-014 alu_valid  in  1  ALU broadcast valid.
REQ-015 alu_rob_idx  in  ROB_SIZE_BIT  ALU result tag.
REQ-016 alu_value  in  32  ALU result.
REQ-017 rob_idx_head  in  ROB_SIZE_BIT  current ROB head tag.
REQ-018 clear  in  1  mispredict flush.
REQ-019 lsb_st_ok  out  1  store finished; ROB may commit its head.
REQ-020 lsb_valid  out  1  load result valid.
REQ-021 lsb_rob_idx  out  ROB_SIZE_BIT  load result tag.
REQ-022 lsb_value  out  32  extended load data.
REQ-023 mem_req  out  1  memory request; held until mem_done.
REQ-024 mem_wr  out  1  1 = store.
REQ-025 mem_addr  out  32  byte address.
REQ-026 mem_len  out  2  0 = byte, 1 = half, 2 = word.
REQ-027 mem_wdata  out  32  store data, LSB-aligned.
REQ-028 mem_done  in  1  one-cycle completion pulse.
REQ-029 mem_rdata  in  32  raw read data, LSB-aligned.

Function
REQ-030 SHALL be an in-order circular FIFO (head/tail wrap modulo 2^LSB_SIZE_BIT plus a count); only the head entry executes.
REQ-031 full SHALL be (count >= 2^LSB_SIZE_BIT - 1), so an issue in the same cycle as full rising is always accepted.
REQ-032 Operand capture: a pending tag matching alu_rob_idx (alu_valid) or lsb_rob_idx (lsb_valid) SHALL resolve in the same cycle, including the issue cycle.
REQ-033 FSM IDLE->BUSY SHALL fire when the head has both operands resolved and is a load, or is a store with its rob_idx equal to rob_idx_head; mem_req/addr/len/wdata SHALL be registered, appearing the next cycle, with addr = v1 + imm (mod 2^32).
REQ-034 BUSY->IDLE on mem_done SHALL pop the head; a load SHALL drive lsb_valid with the sign-extended (LB/LH) or zero-extended (LBU/LHU/LW) value for exactly one cycle, and a store SHALL pulse lsb_st_ok for exactly one cycle.
REQ-035 clear SHALL empty all entries; in BUSY it SHALL enter DRAIN, keeping mem_req until mem_done, discarding the result, then going to IDLE; issue SHALL be ignored in the clear cycle.
REQ-036 Issue and pop in the same cycle SHALL leave count unchanged.

Reset
REQ-037 On reset: count/head/tail = 0, FSM = IDLE, and every output = 0.

Configuration
REQ-038 With LSB_IO_ORDER_EN defined, loads with addr[17:16] = 2'b11 SHALL also wait for rob_idx == rob_idx_head; without it, all loads execute speculatively.

Structure
REQ-039 config.v SHALL hold LSB_SIZE_BIT, ROB_SIZE_BIT, the funct3 constants and the FSM encodings; extension SHALL be done in the combinational sub-module lsb_load_extend.

Verification
REQ-040 LB, v1=0x100, imm=4, mem_rdata=0x80 -> mem_addr=0x104, mem_len=0, lsb_value=0xFFFFFF80 for one cycle.
REQ-041 SW, tag 5, rob_idx_head=3 -> no mem_req; rob_idx_head=5 -> mem_req next cycle, wr=1; mem_done -> lsb_st_ok one cycle.
REQ-042 LW issued with q1=0b1_010, alu_valid, alu_rob_idx=2, alu_value=0x200 in the same cycle -> mem_addr=0x200+imm.
REQ-043 Issue 7 entries with no pop -> full=1 after the 7th; a same-cycle pop plus issue -> count stays 7.
REQ-044 clear during a BUSY load -> mem_req held, no lsb_valid on mem_done, count=0.
